// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared core definitions: register address width, datapath
//               width, architectural register count and the writeback
//               request record (destination + data).
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NREGS      = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Circular buffer of writeback requests. Pointers carry one
//               extra wrap bit, so full and empty can be told apart. A push
//               is taken when the buffer is full, provided a pop happens on
//               the same edge.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               i_push         - write request (rd/data below)
//               i_rd, i_data   - entry to push
//               i_pop          - drop the head entry (ignored when empty)
//               o_head_rd/data - current head entry
//               o_full/o_empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [XLEN-1:0]       i_data,
    input  logic                  i_pop,
    output logic [REG_ADDR_W-1:0] o_head_rd,
    output logic [XLEN-1:0]       o_head_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    wb_req_t          r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_wptr == r_rptr);
    // Same slot, opposite lap -> writer is a full lap ahead of the reader.
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: validity is carried by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= '{rd: i_rd, data: i_data};
        end
    end

    assign o_head_rd   = r_mem[r_rptr[AW-1:0]].rd;
    assign o_head_data = r_mem[r_rptr[AW-1:0]].data;
    assign o_full      = w_full;
    assign o_empty     = w_empty;

endmodule : wb_fifo
`default_nettype wire

// File: rtl/rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_scheduler
// Description : Shares the register file write port between in-order
//               writeback (A, never stalled) and a buffered long-latency
//               result stream (B). Tracks destinations with long-latency
//               results outstanding and raises the decode stall.
// Ports       : clk, reset                - clock, sync active-high reset
//               a_valid/a_rd/a_data       - pipeline writeback
//               b_valid/b_ready/b_rd/b_data - long-latency result handshake
//               iss_valid/iss_rd          - long-latency op issued by decode
//               dec_rs1/dec_rs2/dec_rd    - decode operands for hazard check
//               hazard                    - decode must stall
//               rf_we/rf_waddr/rf_wdata   - register file write port
//               busy                      - work outstanding or buffered
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_scheduler #(
    parameter int NREGS     = 32,
    parameter int BUF_DEPTH = 2,
    parameter int MAX_OUT   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           a_valid,
    input  logic [core_pkg::REG_ADDR_W-1:0] a_rd,
    input  logic [core_pkg::XLEN-1:0]      a_data,
    input  logic                           b_valid,
    output logic                           b_ready,
    input  logic [core_pkg::REG_ADDR_W-1:0] b_rd,
    input  logic [core_pkg::XLEN-1:0]      b_data,
    input  logic                           iss_valid,
    input  logic [core_pkg::REG_ADDR_W-1:0] iss_rd,
    input  logic [core_pkg::REG_ADDR_W-1:0] dec_rs1,
    input  logic [core_pkg::REG_ADDR_W-1:0] dec_rs2,
    input  logic [core_pkg::REG_ADDR_W-1:0] dec_rd,
    output logic                           hazard,
    output logic                           rf_we,
    output logic [core_pkg::REG_ADDR_W-1:0] rf_waddr,
    output logic [core_pkg::XLEN-1:0]      rf_wdata,
    output logic                           busy
);

    import core_pkg::*;

    localparam int              CNT_W     = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] c_MAX_OUT = CNT_W'(MAX_OUT);

    logic [NREGS-1:0] r_pending;
    logic [CNT_W-1:0] r_count;

    logic                  w_a_req;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [REG_ADDR_W-1:0] w_head_rd;
    logic [XLEN-1:0]       w_head_data;
    logic                  w_pop;
    logic                  w_b_ready;
    logic                  w_b_xfer;
    logic                  w_push;
    logic                  w_b_drop;
    logic                  w_hazard;
    logic                  w_issue;
    logic [NREGS-1:0]      w_pend_nxt;
    logic [1:0]            w_dec;
    logic [CNT_W:0]        w_sum;
    logic [CNT_W:0]        w_diff;
    logic [CNT_W-1:0]      w_cnt_nxt;

    // Writes to x0 are architecturally void, so they do not claim the port.
    assign w_a_req  = a_valid && (a_rd != '0);

    // The buffer drains only in cycles the pipeline leaves the port free.
    assign w_pop    = !reset && !w_a_req && !w_fifo_empty;
    assign w_b_ready = reset || !w_fifo_full || w_pop;
    assign w_b_xfer = !reset && b_valid && w_b_ready;
    assign w_push   = w_b_xfer && (b_rd != '0);
    // A result for x0 retires its op without occupying the buffer.
    assign w_b_drop = w_b_xfer && (b_rd == '0);

    wb_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_wb_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_rd        (b_rd),
        .i_data      (b_data),
        .i_pop       (w_pop),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Uses this cycle's bitmap, so a register being written back right now
    // still stalls for one more cycle; issue can never collide with a clear.
    assign w_hazard = !reset &&
                      (r_pending[dec_rs1] || r_pending[dec_rs2] ||
                       r_pending[dec_rd]  ||
                       (iss_valid && (r_count == c_MAX_OUT)));
    assign w_issue  = !reset && iss_valid && !w_hazard;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!reset) begin
            if (w_a_req) begin
                rf_we    = 1'b1;
                rf_waddr = a_rd;
                rf_wdata = a_data;
            end else if (!w_fifo_empty) begin
                rf_we    = 1'b1;
                rf_waddr = w_head_rd;
                rf_wdata = w_head_data;
            end
        end
    end

    always_comb begin
        w_pend_nxt = r_pending;
        if (w_pop) begin
            w_pend_nxt[w_head_rd] = 1'b0;
        end
        if (w_issue && (iss_rd != '0)) begin
            w_pend_nxt[iss_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    // Up to one increment and two decrements (pop + dropped x0 result)
    // per cycle; result clamped to [0, MAX_OUT].
    assign w_dec  = {1'b0, w_pop} + {1'b0, w_b_drop};
    assign w_sum  = {1'b0, r_count} + {{CNT_W{1'b0}}, w_issue};
    assign w_diff = w_sum - (CNT_W + 1)'(w_dec);

    always_comb begin
        w_cnt_nxt = w_diff[CNT_W-1:0];
        if (w_sum < (CNT_W + 1)'(w_dec)) begin
            w_cnt_nxt = '0;
        end else if (w_diff > {1'b0, c_MAX_OUT}) begin
            w_cnt_nxt = c_MAX_OUT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            r_count   <= w_cnt_nxt;
        end
    end

    assign b_ready = w_b_ready;
    assign hazard  = w_hazard;
    assign busy    = !reset && ((r_count != '0) || !w_fifo_empty);

endmodule : rf_wb_scheduler
`default_nettype wire

// File: tb/tb_rf_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_scheduler
// Description : Directed self-checking bench for rf_wb_scheduler. Inputs
//               change 1 time unit after the rising edge, outputs are
//               compared 1 unit later, well clear of the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_scheduler;

    logic        clk;
    logic        reset;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        hazard;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    rf_wb_scheduler #(
        .NREGS     (32),
        .BUF_DEPTH (2),
        .MAX_OUT   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_rd      (b_rd),
        .b_data    (b_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .dec_rs1   (dec_rs1),
        .dec_rs2   (dec_rs2),
        .dec_rd    (dec_rd),
        .hazard    (hazard),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_we"}, {31'b0, rf_we}, 32'd1);
        chk({tag, "_addr"}, {27'b0, rf_waddr}, {27'b0, rd});
        chk({tag, "_data"}, rf_wdata, d);
    endtask

    initial begin
        reset = 1'b1; a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h1;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;

        // Reset held with A active: no write may escape.
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 chk("reset_we", {31'b0, rf_we}, 32'd0);
        end
        reset = 1'b0; a_valid = 1'b0;
        #1;
        chk("post_reset_b_ready", {31'b0, b_ready}, 32'd1);
        chk("post_reset_hazard", {31'b0, hazard}, 32'd0);
        chk("post_reset_busy", {31'b0, busy}, 32'd0);
        chk("post_reset_we", {31'b0, rf_we}, 32'd0);

        // A writeback is combinational; x0 is no request.
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        #1 chk_wr("a_write", 5'd5, 32'hDEADBEEF);
        a_rd = 5'd0;
        #1;
        chk("a_x0_we", {31'b0, rf_we}, 32'd0);
        chk("a_x0_addr", {27'b0, rf_waddr}, 32'd0);
        a_valid = 1'b0;

        // Issue x7, stall on it, B returns, stall persists one cycle.
        tick();
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1 chk("issue7_hazard", {31'b0, hazard}, 32'd0);
        tick();
        iss_valid = 1'b0; dec_rs1 = 5'd7;
        #1;
        chk("rs1_pending_hazard", {31'b0, hazard}, 32'd1);
        chk("busy_outstanding", {31'b0, busy}, 32'd1);
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h1234;
        #1 chk("b7_ready", {31'b0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        #1;
        chk_wr("b7_write", 5'd7, 32'h1234);
        chk("b7_hazard_still", {31'b0, hazard}, 32'd1);
        tick();
        #1;
        chk("b7_hazard_clear", {31'b0, hazard}, 32'd0);
        chk("b7_idle_we", {31'b0, rf_we}, 32'd0);
        chk("b7_busy_clear", {31'b0, busy}, 32'd0);
        dec_rs1 = 5'd0;

        // Three ops outstanding, then B results arrive while A owns the port.
        iss_valid = 1'b1; iss_rd = 5'd9;  tick();
        iss_rd = 5'd10; tick();
        iss_rd = 5'd11; tick();
        iss_valid = 1'b0;
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'hAA;
        #1 chk("fill1_ready", {31'b0, b_ready}, 32'd1);
        tick();
        a_rd = 5'd2; a_data = 32'h22;
        b_rd = 5'd10; b_data = 32'hBB;
        #1;
        chk("fill2_ready", {31'b0, b_ready}, 32'd1);
        chk_wr("fill2_a_wins", 5'd2, 32'h22);
        tick();
        a_rd = 5'd3; a_data = 32'h33;
        b_rd = 5'd11; b_data = 32'hCC;
        #1 chk("full_ready_low", {31'b0, b_ready}, 32'd0);
        tick();
        // A goes idle: head drains and full buffer accepts on the same edge.
        a_valid = 1'b0;
        #1;
        chk_wr("drain_x9", 5'd9, 32'hAA);
        chk("full_pop_ready", {31'b0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        #1 chk_wr("drain_x10", 5'd10, 32'hBB);
        tick();
        #1 chk_wr("drain_x11", 5'd11, 32'hCC);
        tick();
        #1;
        chk("drained_we", {31'b0, rf_we}, 32'd0);
        chk("drained_busy", {31'b0, busy}, 32'd0);

        // Fill to MAX_OUT; a fifth issue must stall and set nothing.
        iss_valid = 1'b1; iss_rd = 5'd12; tick();
        iss_rd = 5'd13; tick();
        iss_rd = 5'd14; tick();
        iss_rd = 5'd15; tick();
        iss_rd = 5'd16;
        #1 chk("max_out_hazard", {31'b0, hazard}, 32'd1);
        tick();
        iss_valid = 1'b0; dec_rs1 = 5'd16;
        #1 chk("blocked_no_pending", {31'b0, hazard}, 32'd0);
        dec_rs1 = 5'd0;
        b_valid = 1'b1; b_rd = 5'd12; b_data = 32'h5;
        tick();
        b_valid = 1'b0;
        #1 chk_wr("ret_x12", 5'd12, 32'h5);
        tick();
        iss_valid = 1'b1; iss_rd = 5'd16;
        #1 chk("reissue_ok", {31'b0, hazard}, 32'd0);
        tick();
        iss_valid = 1'b0; dec_rs2 = 5'd16;
        #1 chk("reissue_pending", {31'b0, hazard}, 32'd1);
        dec_rs2 = 5'd0;
        // Return the four outstanding results back to back.
        b_valid = 1'b1; b_rd = 5'd13; b_data = 32'h13; tick();
        b_rd = 5'd14; b_data = 32'h14; tick();
        b_rd = 5'd15; b_data = 32'h15; tick();
        b_rd = 5'd16; b_data = 32'h16; tick();
        b_valid = 1'b0;
        #1 chk_wr("ret_x16", 5'd16, 32'h16);
        tick();
        #1;
        chk("max_drained_busy", {31'b0, busy}, 32'd0);
        dec_rd = 5'd16;
        #1 chk("x16_released", {31'b0, hazard}, 32'd0);
        dec_rd = 5'd0;

        // x0 destination: counted but never pending, never written.
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        iss_valid = 1'b0;
        #1;
        chk("x0_busy", {31'b0, busy}, 32'd1);
        chk("x0_no_hazard", {31'b0, hazard}, 32'd0);
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFF;
        #1;
        chk("x0_b_ready", {31'b0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        #1;
        chk("x0_no_write", {31'b0, rf_we}, 32'd0);
        chk("x0_busy_clear", {31'b0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_rf_wb_scheduler
`default_nettype wire
